data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 27 ++
 rtl/data_cache_if.sv | 33 +++
 rtl/data_cache_controller_fsm.sv | 90 +++++++++
 rtl/data_cache.sv | 120 ++++++++++++
 tb/tb_data_cache.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_cache_pkg.sv
// data_cache_pkg
// Shared definitions for the direct-mapped data cache: geometry, address
// field widths, controller state encoding and a small word-select helper.
// Ports: none (package).
package data_cache_pkg;

    localparam int SETS       = 8;
    localparam int TAG_W      = 25;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int WORD_W     = 32;
    localparam int BLOCK_W    = 128;
    localparam int BLK_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } cache_state_t;

    // Bit position of the selected 32-bit word inside a 128-bit block.
    function automatic logic [6:0] word_lsb(input logic [OFFSET_W-1:0] offset);
        return {offset, 5'b0};
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// data_cache_if
// Bundles the CPU-side request bus and the main-memory block bus of the cache.
// Modports:
//   slave  - the cache: takes CPU requests and memory responses, drives
//            READDATA/BUSYWAIT and the memory block requests.
//   master - the environment (CPU pipeline plus main memory).
interface data_cache_if;
    import data_cache_pkg::*;

    logic                  MEMREAD;
    logic                  MEMWRITE;
    logic [31:0]           ADDRESS;
    logic [WORD_W-1:0]     WRITEDATA;
    logic [WORD_W-1:0]     READDATA;
    logic                  BUSYWAIT;
    logic                  MEM_READ;
    logic                  MEM_WRITE;
    logic [BLK_ADDR_W-1:0] MEM_ADDRESS;
    logic [BLOCK_W-1:0]    MEM_WRITEDATA;
    logic [BLOCK_W-1:0]    MEM_READDATA;
    logic                  MEM_BUSYWAIT;

    modport slave (
        input  MEMREAD, MEMWRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output MEMREAD, MEMWRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

endinterface

// File: rtl/data_cache_controller_fsm.sv
// cache_controller_fsm
// Miss-handling controller of the data cache.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   hit           - current request hits in the cache
//   dirty         - indexed set is valid and dirty (victim needs writeback)
//   request       - CPU load or store pending
//   mem_busywait  - main memory still busy with the current transfer
//   state         - current controller state
//   busywait      - stall to the CPU
//   mem_read      - block fetch request to memory
//   mem_write     - block writeback request to memory
module cache_controller_fsm
    import data_cache_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hit,
    input  logic         dirty,
    input  logic         request,
    input  logic         mem_busywait,
    output cache_state_t state,
    output logic         busywait,
    output logic         mem_read,
    output logic         mem_write
);

    cache_state_t state_q;
    logic         busy_q;
    logic         mem_read_q;
    logic         mem_write_q;

    // Memory request strobes are set on entry to their state so that they are
    // flop outputs; busy_q covers every non-IDLE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request && !hit) begin
                        busy_q <= 1'b1;
                        if (dirty) begin
                            state_q     <= WRITEBACK;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state_q     <= ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (!mem_busywait) begin
                        state_q    <= UPDATE;
                        mem_read_q <= 1'b0;
                    end
                end
                UPDATE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // A miss must stall the CPU in the same cycle it is presented, so the IDLE
    // miss term is combinational; it is gated by reset so the stall is low
    // while reset is held.
    assign busywait  = busy_q | (rst_n & (state_q == IDLE) & request & ~hit);
    assign state     = state_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: rtl/data_cache.sv
// data_cache
// Direct-mapped, write-back, write-allocate data cache: 8 sets of 16-byte
// blocks, word access only. Hits complete with no stall; misses are handled
// by cache_controller_fsm (optional writeback, then block fetch, then fill).
// Ports:
//   CLK    - clock
//   RESET  - asynchronous active-low reset
//   bus    - data_cache_if.slave: CPU request bus and main-memory block bus
module data_cache
    import data_cache_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    data_cache_if.slave  bus
);

    logic [INDEX_W-1:0]    idx;
    logic [TAG_W-1:0]      req_tag;
    logic [OFFSET_W-1:0]   offset;
    logic                  request;
    logic                  hit;
    logic                  victim_dirty;
    cache_state_t          state;

    logic [SETS-1:0]       valid_q, valid_d;
    logic [SETS-1:0]       dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [TAG_W-1:0]      tag_d  [SETS];
    logic [BLOCK_W-1:0]    data_q [SETS];
    logic [BLOCK_W-1:0]    data_d [SETS];
    logic [BLK_ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic [INDEX_W-1:0]    miss_idx;
    logic [TAG_W-1:0]      miss_tag;
    logic                  unused_addr_bits;

    assign idx              = bus.ADDRESS[6:4];
    assign req_tag          = bus.ADDRESS[31:7];
    assign offset           = bus.ADDRESS[3:2];
    assign unused_addr_bits = ^bus.ADDRESS[1:0];
    assign request          = bus.MEMREAD | bus.MEMWRITE;
    assign hit              = valid_q[idx] && (tag_q[idx] == req_tag);
    assign victim_dirty     = valid_q[idx] & dirty_q[idx];
    assign miss_idx         = miss_addr_q[INDEX_W-1:0];
    assign miss_tag         = miss_addr_q[BLK_ADDR_W-1:INDEX_W];

    cache_controller_fsm u_fsm (
        .clk          (CLK),
        .rst_n        (RESET),
        .hit          (hit),
        .dirty        (victim_dirty),
        .request      (request),
        .mem_busywait (bus.MEM_BUSYWAIT),
        .state        (state),
        .busywait     (bus.BUSYWAIT),
        .mem_read     (bus.MEM_READ),
        .mem_write    (bus.MEM_WRITE)
    );

    assign bus.READDATA = data_q[idx][word_lsb(offset) +: WORD_W];

    // The block address is captured while IDLE so a fill started by a miss
    // lands in the right set even if the CPU withdraws or changes its request.
    always_comb begin
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        miss_addr_d = miss_addr_q;
        case (state)
            IDLE: begin
                miss_addr_d = bus.ADDRESS[31:4];
                if (bus.MEMWRITE && hit) begin
                    data_d[idx][word_lsb(offset) +: WORD_W] = bus.WRITEDATA;
                    dirty_d[idx] = 1'b1;
                end
            end
            UPDATE: begin
                data_d[miss_idx]  = bus.MEM_READDATA;
                tag_d[miss_idx]   = miss_tag;
                valid_d[miss_idx] = 1'b1;
                dirty_d[miss_idx] = 1'b0;
            end
            default: ;
        endcase
    end

    // Memory-side address/data are only meaningful during a transfer and are
    // held at zero otherwise (including under reset, since state is IDLE).
    always_comb begin
        bus.MEM_ADDRESS   = '0;
        bus.MEM_WRITEDATA = '0;
        case (state)
            WRITEBACK: begin
                bus.MEM_ADDRESS   = {tag_q[miss_idx], miss_idx};
                bus.MEM_WRITEDATA = data_q[miss_idx];
            end
            ALLOCATE: bus.MEM_ADDRESS = miss_addr_q;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_addr_q <= '0;
        end else begin
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache
// Self-checking bench for data_cache. Main memory is modelled with a fixed
// 4-cycle busywait; expected load data come from a flat word-level view of
// memory, and expected stalls from a per-set record of which block is held.
module tb_data_cache;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    int   tests  = 0;
    int   failed = 0;

    data_cache_if bus ();

    data_cache dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Main memory model: busy for the first three cycles of a request,
    // transfer completes on the fourth.
    logic [2:0]   mem_cnt      = '0;
    logic [127:0] mem_rdata    = '0;
    logic [127:0] mainmem [128];
    logic [127:0] written      = '0;
    int           wb_count     = 0;
    int           rd_count     = 0;
    logic [27:0]  last_wb_addr = '0;
    logic [27:0]  last_rd_addr = '0;
    logic [127:0] last_wb_data = '0;

    assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (mem_cnt != 3'd3);
    assign bus.MEM_READDATA = mem_rdata;

    function automatic logic [31:0] default_word(input logic [29:0] w);
        return {w, 2'b00} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        logic [6:0]   b   = w[8:2];
        logic [127:0] blk = mainmem[b];
        if (written[b] && w[29:9] == '0) return blk[32*w[1:0] +: 32];
        return default_word(w);
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] a);
        logic [127:0] blk;
        for (int k = 0; k < 4; k++) blk[32*k +: 32] = mem_word({a, 2'(k)});
        return blk;
    endfunction

    always @(posedge CLK) begin
        if (bus.MEM_WRITE && !bus.MEM_BUSYWAIT) begin
            mainmem[bus.MEM_ADDRESS[6:0]] <= bus.MEM_WRITEDATA;
            written[bus.MEM_ADDRESS[6:0]] <= 1'b1;
            last_wb_addr <= bus.MEM_ADDRESS;
            last_wb_data <= bus.MEM_WRITEDATA;
            wb_count     <= wb_count + 1;
            mem_cnt      <= '0;
        end else if (bus.MEM_READ && !bus.MEM_BUSYWAIT) begin
            mem_rdata    <= mem_block(bus.MEM_ADDRESS);
            last_rd_addr <= bus.MEM_ADDRESS;
            rd_count     <= rd_count + 1;
            mem_cnt      <= '0;
        end else if (bus.MEM_READ || bus.MEM_WRITE) begin
            mem_cnt <= mem_cnt + 3'd1;
        end else begin
            mem_cnt <= '0;
        end
    end

    // Reference model: CPU-visible word values (stores since the last reset
    // overlaid on memory) and which block each set holds.
    logic [31:0] ref_mem [logic [29:0]];
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [24:0] m_tag   [8];

    function automatic logic [31:0] ref_word(input logic [29:0] w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return mem_word(w);
    endfunction

    function automatic logic [127:0] ref_block(input logic [27:0] a);
        logic [127:0] blk;
        for (int k = 0; k < 4; k++) blk[32*k +: 32] = ref_word({a, 2'(k)});
        return blk;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
            m_tag[s]   = '0;
        end
        ref_mem.delete();
    endtask

    // One CPU access presented at a negedge; counts stall cycles and checks
    // data and memory traffic against the model.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wd, input string name);
        logic [2:0]   i     = addr[6:4];
        logic [24:0]  t     = addr[31:7];
        bit           hit   = m_valid[i] && (m_tag[i] == t);
        bit           vd    = !hit && m_valid[i] && m_dirty[i];
        int           exp_stall = hit ? 0 : (vd ? 10 : 6);
        logic [27:0]  vblk  = {m_tag[i], i};
        logic [127:0] vdata = ref_block({m_tag[i], i});
        int           wb0   = wb_count;
        int           rd0   = rd_count;
        int           cycles = 0;
        bus.MEMREAD   = rd;
        bus.MEMWRITE  = wr;
        bus.ADDRESS   = addr;
        bus.WRITEDATA = wd;
        #1;
        while (bus.BUSYWAIT === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge CLK);
            #1;
        end
        checkOutput({name, " stall"}, cycles, exp_stall);
        if (rd && !wr) checkOutput({name, " data"}, bus.READDATA, ref_word(addr[31:2]));
        if (vd) begin
            checkOutput({name, " wb count"}, wb_count - wb0, 1);
            checkOutput({name, " wb addr"}, last_wb_addr, vblk);
            checkOutput({name, " wb data"}, last_wb_data, vdata);
        end
        if (!hit) begin
            checkOutput({name, " fill count"}, rd_count - rd0, 1);
            checkOutput({name, " fill addr"}, last_rd_addr, addr[31:4]);
        end else begin
            checkOutput({name, " hit traffic"}, (wb_count - wb0) + (rd_count - rd0), 0);
        end
        @(negedge CLK);
        bus.MEMREAD  = 1'b0;
        bus.MEMWRITE = 1'b0;
        m_valid[i] = 1'b1;
        m_tag[i]   = t;
        if (!hit) m_dirty[i] = 1'b0;
        if (wr) begin
            m_dirty[i] = 1'b1;
            ref_mem[addr[31:2]] = wd;
        end
    endtask

    initial begin
        int guard;
        model_reset();
        bus.MEMREAD   = 1'b1;
        bus.MEMWRITE  = 1'b0;
        bus.ADDRESS   = 32'h0000_0010;
        bus.WRITEDATA = '0;

        // Reset held with a request pending: everything quiet.
        @(negedge CLK);
        @(negedge CLK);
        #1;
        checkOutput("reset BUSYWAIT", bus.BUSYWAIT, 1'b0);
        checkOutput("reset MEM_READ", bus.MEM_READ, 1'b0);
        checkOutput("reset MEM_WRITE", bus.MEM_WRITE, 1'b0);
        checkOutput("reset MEM_ADDRESS", bus.MEM_ADDRESS, 28'h0);
        checkOutput("reset MEM_WRITEDATA", bus.MEM_WRITEDATA, 128'h0);
        bus.MEMREAD = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        // Clean miss, then word 0 of the fetched block.
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, "read 0x10");
        checkOutput("fill addr 0x10", last_rd_addr, 28'h000_0001);

        // Write hit, then read it back.
        applyStimulus(1'b0, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, "write 0x14");
        applyStimulus(1'b1, 1'b0, 32'h0000_0014, 32'h0, "read 0x14");

        // Both strobes on a hit behave as a store.
        applyStimulus(1'b1, 1'b1, 32'h0000_0018, 32'h1234_5678, "rdwr 0x18");
        applyStimulus(1'b1, 1'b0, 32'h0000_0018, 32'h0, "read 0x18");

        // Conflict miss on set 1 with a dirty victim.
        applyStimulus(1'b1, 1'b0, 32'h0000_0094, 32'h0, "read 0x94");
        checkOutput("victim addr", last_wb_addr, 28'h000_0001);
        checkOutput("victim word1", last_wb_data[63:32], 32'hDEAD_BEEF);
        checkOutput("refill addr", last_rd_addr, 28'h000_0009);

        // Reset during ALLOCATE.
        bus.MEMREAD = 1'b1;
        bus.ADDRESS = 32'h0000_02A0;
        guard = 0;
        while (bus.MEM_READ !== 1'b1 && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        checkOutput("alloc entered", bus.MEM_READ, 1'b1);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        checkOutput("midreset MEM_READ", bus.MEM_READ, 1'b0);
        checkOutput("midreset BUSYWAIT", bus.BUSYWAIT, 1'b0);
        checkOutput("midreset MEM_ADDRESS", bus.MEM_ADDRESS, 28'h0);
        bus.MEMREAD = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
        applyStimulus(1'b1, 1'b0, 32'h0000_02A0, 32'h0, "read after reset");

        // Request withdrawn during ALLOCATE: fill still completes.
        bus.MEMREAD = 1'b1;
        bus.ADDRESS = 32'h0000_03B0;
        guard = 0;
        while (bus.MEM_READ !== 1'b1 && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        checkOutput("alloc2 entered", bus.MEM_READ, 1'b1);
        bus.MEMREAD = 1'b0;
        guard = 0;
        #1;
        while (bus.BUSYWAIT === 1'b1 && guard < 20) begin
            @(negedge CLK);
            #1;
            guard++;
        end
        checkOutput("dropped BUSYWAIT", bus.BUSYWAIT, 1'b0);
        checkOutput("dropped MEM_READ", bus.MEM_READ, 1'b0);
        checkOutput("dropped fill addr", last_rd_addr, 28'h000_003B);
        m_valid[3] = 1'b1;
        m_tag[3]   = 25'd7;
        m_dirty[3] = 1'b0;
        @(negedge CLK);
        applyStimulus(1'b1, 1'b0, 32'h0000_03B0, 32'h0, "read 0x3B0");

        // Randomized loads/stores over a small region to force conflicts.
        for (int n = 0; n < 60; n++) begin
            int          op   = int'($urandom_range(0, 2));
            logic [8:0]  word = 9'($urandom_range(0, 511));
            logic [31:0] a    = {21'b0, word, 2'b00};
            applyStimulus(op != 1, op != 0, a, $urandom, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
